// File: rtl/fft_pkg.sv
// Shared types, constants and helpers for the 8-point FFT/IFFT datapaths.
package fft_pkg;

    localparam int DATA_W   = 12;  // re/im width of samples and storage
    localparam int TW_W     = 16;  // re/im width of twiddles
    localparam int TW_F     = 12;  // twiddle fractional bits (0x1000 = +1.0)
    localparam int N_POINTS = 8;   // transform size supported by this datapath

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_t;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } twiddle_t;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } ifft_state_t;

    // Conjugate twiddles W^-t = exp(+j*2*pi*t/8) for the inverse transform.
    localparam twiddle_t ITWIDDLE8 [0:3] = '{
        '{re: 16'sh1000, im: 16'sh0000},
        '{re: 16'sh0B50, im: 16'sh0B50},
        '{re: 16'sh0000, im: 16'sh1000},
        '{re: 16'shF4B0, im: 16'sh0B50}
    };

    // 3-bit bit reversal: input bin k lands at mem[bitrev3(k)] for in-place DIT.
    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Clamp a DATA_W+2 bit intermediate into the signed DATA_W range.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W+1:0] x);
        logic signed [DATA_W+1:0] max_v;
        logic signed [DATA_W+1:0] min_v;
        max_v = {3'b000, {(DATA_W-1){1'b1}}};
        min_v = {3'b111, {(DATA_W-1){1'b0}}};
        if (x > max_v) begin
            return max_v[DATA_W-1:0];
        end else if (x < min_v) begin
            return min_v[DATA_W-1:0];
        end else begin
            return x[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/ifft_stream_if.sv
// Ready/valid stream bundle for the IFFT: bins in, time samples out.
interface ifft_stream_if #(
    parameter int DATA_WIDTH = 12
);
    logic                    ifft_ready_in;
    logic                    ifft_valid_in;
    logic [2*DATA_WIDTH-1:0] ifft_data_in;
    logic                    ifft_ready_out;
    logic                    ifft_valid_out;
    logic [2*DATA_WIDTH-1:0] ifft_data_out;
    logic                    ifft_last_out;

    // The IFFT block itself.
    modport slave (
        output ifft_ready_in,
        input  ifft_valid_in,
        input  ifft_data_in,
        input  ifft_ready_out,
        output ifft_valid_out,
        output ifft_data_out,
        output ifft_last_out
    );

    // Whatever feeds bins in and drains samples out.
    modport master (
        input  ifft_ready_in,
        output ifft_valid_in,
        output ifft_data_in,
        output ifft_ready_out,
        input  ifft_valid_out,
        input  ifft_data_out,
        input  ifft_last_out
    );
endinterface

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with rounding, 1/2 scaling and saturation:
//   P = W*B, A' = sat((A+P)>>>1), B' = sat((A-P)>>>1).
module ifft_butterfly
    import fft_pkg::*;
(
    input  complex_t a,
    input  complex_t b,
    input  twiddle_t w,
    output complex_t a_out,
    output complex_t b_out
);
    localparam int PROD_W = DATA_W + TW_W + 1;  // full-precision complex product
    localparam int SUM_W  = DATA_W + 2;         // headroom for A +/- P
    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(2 ** (TW_F - 1));

    logic signed [PROD_W-1:0] b_re_x, b_im_x, w_re_x, w_im_x;
    logic signed [PROD_W-1:0] p_re_full, p_im_full;
    logic signed [SUM_W-1:0]  p_re, p_im, a_re_x, a_im_x;
    logic signed [SUM_W-1:0]  sum_re, sum_im, dif_re, dif_im;

    // Twiddle multiply, round to the data grid, then halve and clamp both legs.
    always_comb begin
        b_re_x    = PROD_W'(b.re);
        b_im_x    = PROD_W'(b.im);
        w_re_x    = PROD_W'(w.re);
        w_im_x    = PROD_W'(w.im);
        p_re_full = b_re_x * w_re_x - b_im_x * w_im_x;
        p_im_full = b_re_x * w_im_x + b_im_x * w_re_x;
        // Rounded product always fits SUM_W because |W| <= 1.0.
        p_re      = SUM_W'((p_re_full + ROUND_BIAS) >>> TW_F);
        p_im      = SUM_W'((p_im_full + ROUND_BIAS) >>> TW_F);
        a_re_x    = SUM_W'(a.re);
        a_im_x    = SUM_W'(a.im);
        sum_re    = (a_re_x + p_re) >>> 1;
        sum_im    = (a_im_x + p_im) >>> 1;
        dif_re    = (a_re_x - p_re) >>> 1;
        dif_im    = (a_im_x - p_im) >>> 1;
        a_out.re  = sat(sum_re);
        a_out.im  = sat(sum_im);
        b_out.re  = sat(dif_re);
        b_out.im  = sat(dif_im);
    end

endmodule

// File: rtl/ifft_stream.sv
// 8-point radix-2 DIT inverse FFT over a ready/valid stream. A frame of bins is
// loaded in bit-reversed order, transformed in place by one butterfly over 12
// cycles, then streamed out in natural order with an overall 1/8 scale.
module ifft_stream
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int TW_WIDTH   = 16,
    parameter int TW_FRAC    = 12,
    parameter int FFT_POINTS = 8
)(
    input logic          clk,
    input logic          rst,
    ifft_stream_if.slave bus
);
    if (FFT_POINTS != N_POINTS) begin : g_points_check
        $error("ifft_stream: FFT_POINTS must be 8");
    end
    if (DATA_WIDTH != DATA_W || TW_WIDTH != TW_W || TW_FRAC != TW_F) begin : g_width_check
        $error("ifft_stream: widths must match fft_pkg");
    end

    localparam logic [3:0] LAST_BFLY = 4'd11;  // 3 stages x 4 butterflies - 1

    ifft_state_t state_q, state_d;
    logic [2:0]  ld_cnt_q, ld_cnt_d;
    logic [3:0]  cmp_cnt_q, cmp_cnt_d;
    logic [2:0]  un_cnt_q, un_cnt_d;
    logic        ready_in_q, ready_in_d;
    logic        valid_out_q, valid_out_d;
    logic        last_out_q, last_out_d;
    complex_t    mem_q [8];
    complex_t    mem_d [8];

    logic [1:0]  stage;
    logic [1:0]  bfly;
    logic [2:0]  h, j, top_idx, bot_idx;
    logic [1:0]  tw_idx;
    complex_t    bf_a, bf_b, bf_a_out, bf_b_out;
    twiddle_t    bf_w;

    // Map the compute counter onto stage/butterfly operand addresses and twiddle.
    always_comb begin
        stage   = cmp_cnt_q[3:2];
        bfly    = cmp_cnt_q[1:0];
        h       = 3'd1 << stage;
        j       = {1'b0, bfly} & (h - 3'd1);
        top_idx = (({1'b0, bfly} >> stage) << (stage + 2'd1)) + j;
        bot_idx = top_idx + h;
        tw_idx  = 2'(j << (2'd2 - stage));
        bf_a    = mem_q[top_idx];
        bf_b    = mem_q[bot_idx];
        bf_w    = ITWIDDLE8[tw_idx];
    end

    ifft_butterfly u_bfly (
        .a     (bf_a),
        .b     (bf_b),
        .w     (bf_w),
        .a_out (bf_a_out),
        .b_out (bf_b_out)
    );

    // Next-state, counter, storage and registered-output logic for LOAD/COMPUTE/UNLOAD.
    always_comb begin
        // NOTE: every _d starts as a copy of its _q so no branch can leave a latch.
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        cmp_cnt_d   = cmp_cnt_q;
        un_cnt_d    = un_cnt_q;
        valid_out_d = valid_out_q;
        last_out_d  = last_out_q;
        mem_d       = mem_q;

        case (state_q)
            LOAD: begin
                if (bus.ifft_valid_in && ready_in_q) begin
                    mem_d[bitrev3(ld_cnt_q)] = bus.ifft_data_in;
                    ld_cnt_d = ld_cnt_q + 3'd1;
                    if (ld_cnt_q == 3'd7) begin
                        state_d   = COMPUTE;
                        cmp_cnt_d = '0;
                    end
                end
            end
            COMPUTE: begin
                mem_d[top_idx] = bf_a_out;
                mem_d[bot_idx] = bf_b_out;
                cmp_cnt_d      = cmp_cnt_q + 4'd1;
                if (cmp_cnt_q == LAST_BFLY) begin
                    state_d     = UNLOAD;
                    cmp_cnt_d   = '0;
                    un_cnt_d    = '0;
                    valid_out_d = 1'b1;
                    last_out_d  = 1'b0;
                end
            end
            UNLOAD: begin
                if (bus.ifft_ready_out) begin
                    if (un_cnt_q == 3'd7) begin
                        state_d     = LOAD;
                        un_cnt_d    = '0;
                        ld_cnt_d    = '0;
                        valid_out_d = 1'b0;
                        last_out_d  = 1'b0;
                    end else begin
                        un_cnt_d   = un_cnt_q + 3'd1;
                        last_out_d = (un_cnt_q == 3'd6);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Input is only ever offered in LOAD, so it drops the cycle after the 8th accept.
        ready_in_d = (state_d == LOAD);
    end

    // FSM and control registers; synchronous reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
        if (rst) begin
            state_q     <= LOAD;
            ld_cnt_q    <= '0;
            cmp_cnt_q   <= '0;
            un_cnt_q    <= '0;
            ready_in_q  <= 1'b0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            cmp_cnt_q   <= cmp_cnt_d;
            un_cnt_q    <= un_cnt_d;
            ready_in_q  <= ready_in_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
        end
    end

    // Frame storage.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; every frame overwrites all 8 entries before use.
        mem_q <= mem_d;
    end

    assign bus.ifft_ready_in  = ready_in_q;
    assign bus.ifft_valid_out = valid_out_q;
    assign bus.ifft_last_out  = last_out_q;
    assign bus.ifft_data_out  = valid_out_q ? mem_q[un_cnt_q] : '0;

endmodule
